// File: rtl/dbg_pkg.sv
// Shared definitions for the host-side debug scanner: opcodes, FSM encoding, defaults.
package dbg_pkg;

   localparam logic [1:0] OP_SNAP = 2'b00;
   localparam logic [1:0] OP_STEP = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_RUN  = 2'b11;

   localparam int DEF_LED_W     = 27;
   localparam int DEF_SEL_COUNT = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_LOAD   = 3'd2,
      S_STEP   = 3'd3,
      S_SETTLE = 3'd4,
      S_SAMPLE = 3'd5,
      S_SEND   = 3'd6
   } state_t;

endpackage

// File: rtl/dbg_settle_counter.sv
// Loadable 4-bit down-counter timing the selector settle window; done marks the final cycle.
module dbg_settle_counter (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       en,
   output logic       done
);

   logic [3:0] count;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (en && count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign done = (count == 4'd1);

endmodule

// File: rtl/sys_debug_scanner.sv
// Host-side debug scanner: freezes the core, sweeps every selector view and streams
// each captured word out with its selector tag; also issues step, PC-load and run.
//
// state  | meaning
// IDLE   | core frozen, waiting for a command
// RUN    | core free-running, commands still accepted
// LOAD   | one-cycle PC-load strobe with core enabled
// STEP   | one-cycle core enable
// SETTLE | selector changed, waiting for the core debug mux to settle
// SAMPLE | capture SYS_leds into the output register
// SEND   | holding the captured word until the consumer takes it
module sys_debug_scanner
   import dbg_pkg::*;
#(
   parameter int SEL_COUNT     = DEF_SEL_COUNT,
   parameter int LED_W         = DEF_LED_W,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             SYS_clk,
   input  logic             SYS_reset,
   input  logic             DBG_cmd_valid,
   output logic             DBG_cmd_ready,
   input  logic [1:0]       DBG_cmd_op,
   input  logic [7:0]       DBG_cmd_pc,
   input  logic [LED_W-1:0] SYS_leds,
   output logic [7:0]       SYS_output_sel,
   output logic             SYS_load,
   output logic [7:0]       SYS_pc_val,
   output logic             DBG_hold,
   output logic             DBG_out_valid,
   input  logic             DBG_out_ready,
   output logic [LED_W-1:0] DBG_out_data,
   output logic [7:0]       DBG_out_tag,
   output logic             DBG_out_last
);

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
   localparam logic [7:0] SEL_LAST    = 8'(SEL_COUNT - 1);

   state_t state;
   logic   cmd_fire;
   logic   cnt_load;
   logic   cnt_done;

   assign DBG_cmd_ready = (state == S_IDLE) || (state == S_RUN);
   assign cmd_fire      = DBG_cmd_valid && DBG_cmd_ready;

   // The settle window restarts on every edge that moves into SETTLE.
   always_comb begin
      cnt_load = 1'b0;
      case (state)
         S_IDLE, S_RUN:  cnt_load = cmd_fire && (DBG_cmd_op == OP_SNAP);
         S_STEP, S_LOAD: cnt_load = 1'b1;
         S_SEND:         cnt_load = DBG_out_ready && !DBG_out_last;
         default:        cnt_load = 1'b0;
      endcase
   end

   dbg_settle_counter u_settle (
      .clk_sys  (SYS_clk),
      .rst      (SYS_reset),
      .load     (cnt_load),
      .load_val (SETTLE_INIT),
      .en       (state == S_SETTLE),
      .done     (cnt_done)
   );

   always_ff @(posedge SYS_clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         state          <= S_IDLE;
         SYS_output_sel <= 8'd0;
         SYS_load       <= 1'b0;
         SYS_pc_val     <= 8'd0;
         DBG_hold       <= 1'b1;
         DBG_out_valid  <= 1'b0;
         DBG_out_data   <= '0;
         DBG_out_tag    <= 8'd0;
         DBG_out_last   <= 1'b0;
      end else begin
         SYS_load <= 1'b0;
         case (state)
            S_IDLE, S_RUN: begin
               if (cmd_fire) begin
                  DBG_hold <= 1'b1;
                  case (DBG_cmd_op)
                     OP_SNAP: begin
                        state          <= S_SETTLE;
                        SYS_output_sel <= 8'd0;
                     end
                     OP_STEP: begin
                        state    <= S_STEP;
                        DBG_hold <= 1'b0;
                     end
                     OP_LOAD: begin
                        state      <= S_LOAD;
                        SYS_pc_val <= DBG_cmd_pc;
                        SYS_load   <= 1'b1;
                        DBG_hold   <= 1'b0;
                     end
                     default: begin
                        state    <= S_RUN;
                        DBG_hold <= 1'b0;
                     end
                  endcase
               end
            end
            S_STEP, S_LOAD: begin
               state          <= S_SETTLE;
               DBG_hold       <= 1'b1;
               SYS_output_sel <= 8'd0;
            end
            S_SETTLE: begin
               if (cnt_done) state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               DBG_out_data  <= SYS_leds;
               DBG_out_tag   <= SYS_output_sel;
               DBG_out_last  <= (SYS_output_sel == SEL_LAST);
               DBG_out_valid <= 1'b1;
               state         <= S_SEND;
            end
            S_SEND: begin
               if (DBG_out_ready) begin
                  DBG_out_valid <= 1'b0;
                  if (DBG_out_last) begin
                     state          <= S_IDLE;
                     SYS_output_sel <= 8'd0;
                  end else begin
                     state          <= S_SETTLE;
                     SYS_output_sel <= SYS_output_sel + 8'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_debug_scanner.sv
// Directed self-checking bench for sys_debug_scanner with a tiny core model behind SYS_leds.
module tb_sys_debug_scanner;
   import dbg_pkg::*;

   logic        SYS_clk = 1'b0;
   logic        SYS_reset = 1'b0;
   logic        DBG_cmd_valid = 1'b0;
   logic        DBG_cmd_ready;
   logic [1:0]  DBG_cmd_op = 2'b00;
   logic [7:0]  DBG_cmd_pc = 8'd0;
   logic [26:0] SYS_leds;
   logic [7:0]  SYS_output_sel;
   logic        SYS_load;
   logic [7:0]  SYS_pc_val;
   logic        DBG_hold;
   logic        DBG_out_valid;
   logic        DBG_out_ready = 1'b0;
   logic [26:0] DBG_out_data;
   logic [7:0]  DBG_out_tag;
   logic        DBG_out_last;

   int checks = 0;
   int failures = 0;

   sys_debug_scanner dut (
      .SYS_clk        (SYS_clk),
      .SYS_reset      (SYS_reset),
      .DBG_cmd_valid  (DBG_cmd_valid),
      .DBG_cmd_ready  (DBG_cmd_ready),
      .DBG_cmd_op     (DBG_cmd_op),
      .DBG_cmd_pc     (DBG_cmd_pc),
      .SYS_leds       (SYS_leds),
      .SYS_output_sel (SYS_output_sel),
      .SYS_load       (SYS_load),
      .SYS_pc_val     (SYS_pc_val),
      .DBG_hold       (DBG_hold),
      .DBG_out_valid  (DBG_out_valid),
      .DBG_out_ready  (DBG_out_ready),
      .DBG_out_data   (DBG_out_data),
      .DBG_out_tag    (DBG_out_tag),
      .DBG_out_last   (DBG_out_last)
   );

   always #5 SYS_clk = ~SYS_clk;

   // Core model: PC advances while enabled, loads on the strobe; selector 7 exposes the PC.
   logic [7:0] core_pc = 8'h07;
   always @(posedge SYS_clk) begin
      if (DBG_hold === 1'b0) core_pc <= (SYS_load === 1'b1) ? SYS_pc_val : core_pc + 8'd1;
   end

   always_comb begin
      if (SYS_output_sel == 8'd7) SYS_leds = {11'd0, core_pc, 8'h77};
      else                        SYS_leds = 27'({4'd0, SYS_output_sel} * 12'h111);
   end

   function automatic logic [26:0] exp_word(input logic [7:0] k);
      if (k == 8'd7) return {11'd0, core_pc, 8'h77};
      return 27'({4'd0, k} * 12'h111);
   endfunction

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge SYS_clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] pc);
      int w = 0;
      DBG_cmd_op    = op;
      DBG_cmd_pc    = pc;
      DBG_cmd_valid = 1'b1;
      while (DBG_cmd_ready !== 1'b1 && w < 50) begin
         tick();
         w++;
      end
      chk("cmd_accept", 32'(DBG_cmd_ready), 32'd1);
      tick();
      DBG_cmd_valid = 1'b0;
   endtask

   // Issues a command that ends in a sweep and checks every word, its timing and the hold/load pins.
   task automatic snap_run(input logic [1:0] op, input logic [7:0] pc, input logic [7:0] stall_tag,
                           input int stall_n, output logic [26:0] last_data);
      int   cyc = 0, n = 0, prev = 0, hold_low = 0, load_hi = 0;
      logic ready_bad = 1'b0, stall_done = 1'b0, stall_bad = 1'b0, done = 1'b0;
      last_data     = '0;
      DBG_out_ready = 1'b1;
      send_cmd(op, pc);
      while (!done && cyc < 400) begin
         if (DBG_hold !== 1'b1) hold_low++;
         if (SYS_load === 1'b1) begin
            load_hi++;
            chk("load_hold", 32'(DBG_hold), 32'd0);
            chk("load_pc", 32'(SYS_pc_val), 32'(pc));
         end
         if (DBG_cmd_ready !== 1'b0) ready_bad = 1'b1;
         if (DBG_out_valid === 1'b1) begin
            if (!stall_done && DBG_out_tag == stall_tag) begin
               stall_done    = 1'b1;
               DBG_out_ready = 1'b0;
               for (int i = 0; i < stall_n; i++) begin
                  tick();
                  cyc++;
                  if (DBG_out_valid !== 1'b1 || DBG_out_tag !== stall_tag ||
                      DBG_out_data !== exp_word(stall_tag) || SYS_output_sel !== stall_tag ||
                      DBG_hold !== 1'b1) stall_bad = 1'b1;
               end
               chk("stall_stable", 32'(stall_bad), 32'd0);
               DBG_out_ready = 1'b1;
            end
            chk("tag", 32'(DBG_out_tag), 32'(n));
            chk("data", 32'(DBG_out_data), 32'(exp_word(8'(n))));
            chk("last", 32'(DBG_out_last), 32'(n == 7));
            chk("spacing", 32'(cyc - prev),
                (n == 0) ? ((op == OP_SNAP) ? 32'd3 : 32'd4)
                         : 32'(4 + ((n == int'(stall_tag)) ? stall_n : 0)));
            prev      = cyc;
            last_data = DBG_out_data;
            n++;
            if (DBG_out_last === 1'b1) done = 1'b1;
         end
         if (!done) begin
            tick();
            cyc++;
         end
      end
      chk("word_count", 32'(n), 32'd8);
      chk("hold_low_cycles", 32'(hold_low), (op == OP_SNAP) ? 32'd0 : 32'd1);
      chk("load_pulse_cycles", 32'(load_hi), (op == OP_LOAD) ? 32'd1 : 32'd0);
      chk("ready_low_in_sweep", 32'(ready_bad), 32'd0);
      tick();
      chk("valid_drop", 32'(DBG_out_valid), 32'd0);
      chk("ready_idle", 32'(DBG_cmd_ready), 32'd1);
      chk("sel_back_zero", 32'(SYS_output_sel), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [26:0] ld;
      int          bad;
      int          w;

      // Asynchronous reset before any clock edge.
      #3 SYS_reset = 1'b1;
      #1;
      chk("rst_hold", 32'(DBG_hold), 32'd1);
      chk("rst_valid", 32'(DBG_out_valid), 32'd0);
      chk("rst_sel", 32'(SYS_output_sel), 32'd0);
      chk("rst_ready", 32'(DBG_cmd_ready), 32'd1);
      chk("rst_load", 32'(SYS_load), 32'd0);
      tick();
      tick();
      SYS_reset = 1'b0;
      tick();

      snap_run(OP_SNAP, 8'd0, 8'hFF, 0, ld);
      chk("snap_tag7_word", 32'(ld), 32'h777);

      snap_run(OP_SNAP, 8'd0, 8'd3, 10, ld);

      snap_run(OP_LOAD, 8'h20, 8'hFF, 0, ld);
      chk("load_pc_in_word", 32'(ld[15:8]), 32'h20);
      chk("pc_val_held", 32'(SYS_pc_val), 32'h20);

      snap_run(OP_STEP, 8'd0, 8'hFF, 0, ld);
      chk("step_pc_in_word", 32'(ld[15:8]), 32'h21);

      // Free run for 50 cycles with a redundant RUN in the middle.
      send_cmd(OP_RUN, 8'd0);
      bad = 0;
      for (int i = 0; i < 25; i++) begin
         if (DBG_hold !== 1'b0 || DBG_cmd_ready !== 1'b1) bad++;
         tick();
      end
      send_cmd(OP_RUN, 8'd0);
      for (int i = 0; i < 24; i++) begin
         if (DBG_hold !== 1'b0 || DBG_cmd_ready !== 1'b1) bad++;
         tick();
      end
      chk("run_hold_low", 32'(bad), 32'd0);
      snap_run(OP_SNAP, 8'd0, 8'hFF, 0, ld);

      // Reset while tag 4 is waiting in SEND.
      DBG_out_ready = 1'b1;
      send_cmd(OP_SNAP, 8'd0);
      w = 0;
      while (!(DBG_out_valid === 1'b1 && DBG_out_tag === 8'd4) && w < 100) begin
         tick();
         w++;
      end
      DBG_out_ready = 1'b0;
      chk("reached_tag4", 32'(DBG_out_tag), 32'd4);
      #2 SYS_reset = 1'b1;
      #1;
      chk("midrst_valid", 32'(DBG_out_valid), 32'd0);
      chk("midrst_sel", 32'(SYS_output_sel), 32'd0);
      chk("midrst_hold", 32'(DBG_hold), 32'd1);
      chk("midrst_tag", 32'(DBG_out_tag), 32'd0);
      tick();
      SYS_reset = 1'b0;
      tick();
      snap_run(OP_SNAP, 8'd0, 8'hFF, 0, ld);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sys_debug_scanner.md
Name: sys_debug_scanner

Overview:
- Host-side end of the core's debug interface: drives `SYS_output_sel`, `SYS_load` and `SYS_pc_val`, and samples the 27-bit `SYS_leds` word.
- Sweeps every selector and captures each view of core state into a register.
- Streams each captured word out over a valid/ready port, tagged with its selector index.
- Provides a core clock-enable (`DBG_hold`) so the core stays frozen while a snapshot is taken. Supports single-step, PC load and free-run commands.

Parameters:
- SEL_COUNT, 8, number of selectors swept per snapshot (indices 0..SEL_COUNT-1, max 256).
- LED_W, 27, width of the sampled `SYS_leds` word.
- SETTLE_CYCLES, 2, wait after changing the selector before sampling (legal range 1..15).

Ports:
- SYS_clk  in  1  single clock.
- SYS_reset  in  1  asynchronous, active-high reset.
- DBG_cmd_valid  in  1  command present.
- DBG_cmd_ready  out  1  command accepted when high together with valid.
- DBG_cmd_op  in  2  command: 00 SNAP, 01 STEP, 10 LOAD, 11 RUN.
- DBG_cmd_pc  in  8  PC value used by LOAD.
- SYS_leds  in  LED_W  debug word from the core.
- SYS_output_sel  out  8  selector driven to the core.
- SYS_load  out  1  PC-load strobe to the core.
- SYS_pc_val  out  8  PC value to the core.
- DBG_hold  out  1  high = core clock-enable deasserted (core frozen).
- DBG_out_valid  out  1  captured word available.
- DBG_out_ready  in  1  consumer accepts.
- DBG_out_data  out  LED_W  captured word.
- DBG_out_tag  out  8  selector index of `DBG_out_data`.
- DBG_out_last  out  1  high on the final word of a snapshot.

Behaviour:
- Clocking and reset: one clock, `SYS_clk`. Reset is asynchronous and active-high on `SYS_reset`.
- Reset values: state IDLE, `SYS_output_sel`=0, `SYS_load`=0, `SYS_pc_val`=0, `DBG_hold`=1, `DBG_out_valid`=0, `DBG_out_data`=0, `DBG_out_tag`=0, `DBG_out_last`=0, settle counter=0.
- `DBG_cmd_ready`:
  - High only in IDLE and RUN; combinational from state.
  - A command is taken only on a cycle where `DBG_cmd_valid` and `DBG_cmd_ready` are both high.
- States: IDLE, RUN, LOAD, STEP, SETTLE, SAMPLE, SEND.
- IDLE:
  - `DBG_hold`=1.
  - SNAP goes to SETTLE with sel=0 and counter=SETTLE_CYCLES.
  - STEP goes to STEP.
  - LOAD latches `DBG_cmd_pc` into `SYS_pc_val` and goes to LOAD.
  - RUN goes to RUN.
- STEP: `DBG_hold`=0 for exactly one cycle (the core advances one instruction), then SETTLE with sel=0.
- LOAD:
  - `SYS_load`=1 and `DBG_hold`=0 for exactly one cycle, so the core PC captures `SYS_pc_val`.
  - Then SETTLE with sel=0. `SYS_load` returns to 0 and `SYS_pc_val` holds its value.
- RUN:
  - `DBG_hold`=0 continuously.
  - Accepting any command sets `DBG_hold`=1 on the next cycle and dispatches exactly as from IDLE, with no extra hold gap.
  - A RUN received while in RUN is a no-op.
- SETTLE: `DBG_hold`=1. Counter decrements each cycle; at 1, go to SAMPLE.
- SAMPLE (one cycle):
  - Registers `SYS_leds` into `DBG_out_data`, tag=sel, `DBG_out_last`=(sel==SEL_COUNT-1), `DBG_out_valid`=1.
  - Goes to SEND.
- SEND:
  - Data, tag and last stay stable while `DBG_out_ready`=0.
  - On handshake, `DBG_out_valid` drops the next cycle.
  - If last: go to IDLE, sel returns to 0.
  - Else: sel+1, counter reloads, go to SETTLE.
- Latency:
  - First `DBG_out_valid` rises SETTLE_CYCLES+1 cycles after the SNAP accept edge.
  - Each following word rises SETTLE_CYCLES+1 cycles after the previous handshake.
- Selector updates: `SYS_output_sel` changes only on the SEND→SETTLE or dispatch edge, never during SETTLE or SAMPLE.
- Selector width rule: the counter is 8 bits and compares against SEL_COUNT-1. No wrap is possible within a snapshot.
- Core freeze: `DBG_hold`=1 in every state except RUN and the single STEP or LOAD cycle, so the core never advances during a sweep.
- Reset mid-operation: immediately returns to the reset values. Any in-flight word is dropped; the consumer must discard a partial snapshot (no `DBG_out_last` was seen).
- `SYS_load` must never be high for more than one cycle or while `DBG_hold`=1.

Decomposition:
- Shared package `dbg_pkg`:
  - Opcode constants OP_SNAP=2'b00, OP_STEP=2'b01, OP_LOAD=2'b10, OP_RUN=2'b11.
  - State encoding constants.
  - Default LED_W=27, SEL_COUNT=8.
- One natural sub-module: `dbg_settle_counter`, a loadable 4-bit down-counter with a `done` flag, reused for SETTLE timing.

Test Plan:
- Reset:
  - Stimulus: assert `SYS_reset` mid-cycle.
  - Response: `DBG_hold`=1, `DBG_out_valid`=0 and `SYS_output_sel`=0 without waiting for a clock edge; `DBG_cmd_ready`=1.
- SNAP with `DBG_out_ready` tied 1 and model `SYS_leds`=sel*0x111:
  - Exactly 8 words, tags 0..7, data 0x000..0x777.
  - Last high only on tag 7; words spaced SETTLE_CYCLES+2 cycles apart.
  - `DBG_hold` never low.
- SNAP with `DBG_out_ready` held 0 for 10 cycles on tag 3: data and tag stay stable, `SYS_output_sel` stays 3, and no tag is skipped or repeated.
- LOAD with `DBG_cmd_pc`=0x20:
  - `SYS_load`=1, `SYS_pc_val`=0x20 and `DBG_hold`=0 for exactly one cycle.
  - A snapshot follows whose tag-7 data carries PC 0x20 in bits[15:8].
- RUN, then SNAP after 50 cycles:
  - `DBG_hold` is 0 for the 50 cycles, then 1 from the cycle after SNAP is accepted.
  - `DBG_cmd_ready`=0 until tag-7 handshake.
- Reset asserted during SEND of tag 4: `DBG_out_valid` drops asynchronously; a new SNAP then restarts at tag 0.
